wash_cycle_controller: RTL

Top-level wash-cycle sequencer for the washing machine. Latches the user's wash mode and the temperature chosen on the temperature incrementor, then steps the machine through fill, heat, wash, drain, rinse and spin by driving the valve, heater, pump and motor. Gates the incrementor so the temperature can only be changed while the machine is idle. Handles pause, door, cancel and timeout faults.

---
 rtl/wash_cycle_controller.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: wash-cycle sequencer driving valve, heater, pump and motor.
// Optional PREWASH_EN inserts a PREWASH state after FILL for modes with wash_mode[0]=1.
module wash_cycle_controller #(
   parameter int FILL_TIMEOUT = 64,
   parameter int HEAT_TIMEOUT = 128,
   parameter int WASH_CYCLES  = 16,
   parameter int RINSE_CYCLES = 8,
   parameter int DRAIN_CYCLES = 8,
   parameter int SPIN_CYCLES  = 12
`ifdef PREWASH_EN
   , parameter int PREWASH_CYCLES = 6
`endif
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       start_i,
   input  logic       pause_i,
   input  logic       cancel_i,
   input  logic       door_closed_i,
   input  logic       water_full_i,
   input  logic [2:0] wash_mode_i,
   input  logic [5:0] target_temp_i,
   input  logic [5:0] water_temp_i,
   output logic       temp_adjust_en_o,
   output logic       door_lock_o,
   output logic       water_valve_o,
   output logic       heater_on_o,
   output logic       drain_pump_o,
   output logic       motor_on_o,
   output logic       motor_fast_o,
   output logic       done_o,
   output logic       fault_o,
   output logic [3:0] state_o
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, FILL = 4'd1, HEAT = 4'd2, WASH = 4'd3, DRAIN = 4'd4,
      RINSE = 4'd5, SPIN = 4'd6, DONE = 4'd7, FAULT = 4'd8
`ifdef PREWASH_EN
      , PREWASH = 4'd9
`endif
   } state_e;

   state_e      state_q, state_d, heat_state;
   logic [15:0] timer_q, timer_d, tdec, wash_len, heat_timer;
   logic [1:0]  rinses_q, rinses_d, mode_q, mode_d;
   logic [5:0]  target_q, target_d;
   logic        cancel_q, cancel_d, hold, tz, run_d;

   function automatic logic is_locked(input state_e s);
`ifdef PREWASH_EN
      return s inside {FILL, HEAT, WASH, DRAIN, RINSE, SPIN, PREWASH};
`else
      return s inside {FILL, HEAT, WASH, DRAIN, RINSE, SPIN};
`endif
   endfunction

   assign tdec       = timer_q - 16'd1;
   assign tz         = timer_q == 16'd0;
   assign wash_len   = 16'(WASH_CYCLES * (int'(mode_q) + 1));
   // a zero target needs no heating, so the water goes straight to WASH
   assign heat_state = (target_q == 6'd0) ? WASH : HEAT;
   assign heat_timer = (target_q == 6'd0) ? wash_len - 16'd1 : 16'(HEAT_TIMEOUT - 1);
   assign run_d      = !hold;
   assign state_o    = state_q;

   // next-state: cancel beats pause/door, which beats timeouts and sensor exits
   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cancel_d = cancel_q;
      rinses_d = rinses_q;
      mode_d   = mode_q;
      target_d = target_q;
      hold     = 1'b0;
      if (is_locked(state_q) && cancel_i && state_q != DRAIN) begin
         cancel_d = 1'b1;
         state_d  = DRAIN;
         timer_d  = 16'(DRAIN_CYCLES - 1);
      end else if (is_locked(state_q) && !cancel_i && (pause_i || !door_closed_i)) begin
         hold = 1'b1;
      end else begin
         case (state_q)
            IDLE: if (start_i && door_closed_i) begin
               state_d  = FILL;
               timer_d  = 16'(FILL_TIMEOUT - 1);
               mode_d   = wash_mode_i[1:0];
               target_d = target_temp_i;
               rinses_d = wash_mode_i[2] ? 2'd2 : 2'd1;
               cancel_d = 1'b0;
            end
            FILL: if (water_full_i) begin
`ifdef PREWASH_EN
               state_d = mode_q[0] ? PREWASH : heat_state;
               timer_d = mode_q[0] ? 16'(PREWASH_CYCLES - 1) : heat_timer;
`else
               state_d = heat_state;
               timer_d = heat_timer;
`endif
            end else if (tz) state_d = FAULT;
            else timer_d = tdec;
            HEAT: if (water_temp_i >= target_q) begin
               state_d = WASH;
               timer_d = wash_len - 16'd1;
            end else if (tz) state_d = FAULT;
            else timer_d = tdec;
            WASH: begin
               state_d = tz ? DRAIN : WASH;
               timer_d = tz ? 16'(DRAIN_CYCLES - 1) : tdec;
            end
            DRAIN: begin
               cancel_d = cancel_q | cancel_i;
               if (!tz) timer_d = tdec;
               else if (cancel_q || cancel_i) state_d = DONE;
               else if (rinses_q != 2'd0) begin
                  state_d  = RINSE;
                  timer_d  = 16'(RINSE_CYCLES - 1);
                  rinses_d = rinses_q - 2'd1;
               end else begin
                  state_d = SPIN;
                  timer_d = 16'(SPIN_CYCLES - 1);
               end
            end
            RINSE: begin
               state_d = tz ? DRAIN : RINSE;
               timer_d = tz ? 16'(DRAIN_CYCLES - 1) : tdec;
            end
            SPIN: begin
               state_d = tz ? DONE : SPIN;
               timer_d = tz ? 16'd0 : tdec;
            end
`ifdef PREWASH_EN
            PREWASH: begin
               state_d = tz ? heat_state : PREWASH;
               timer_d = tz ? heat_timer : tdec;
            end
`endif
            DONE:  state_d = (!door_closed_i || start_i) ? IDLE : DONE;
            FAULT: state_d = cancel_i ? IDLE : FAULT;
            default: state_d = IDLE;
         endcase
      end
   end

   // state registers and output decodes of the state being entered
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q          <= IDLE;
         timer_q          <= 16'd0;
         cancel_q         <= 1'b0;
         rinses_q         <= 2'd0;
         mode_q           <= 2'd0;
         target_q         <= 6'd0;
         temp_adjust_en_o <= 1'b1;
         door_lock_o      <= 1'b0;
         water_valve_o    <= 1'b0;
         heater_on_o      <= 1'b0;
         drain_pump_o     <= 1'b0;
         motor_on_o       <= 1'b0;
         motor_fast_o     <= 1'b0;
         done_o           <= 1'b0;
         fault_o          <= 1'b0;
      end else begin
         state_q          <= state_d;
         timer_q          <= timer_d;
         cancel_q         <= cancel_d;
         rinses_q         <= rinses_d;
         mode_q           <= mode_d;
         target_q         <= target_d;
         temp_adjust_en_o <= state_d == IDLE;
         door_lock_o      <= is_locked(state_d);
         water_valve_o    <= run_d && (state_d == FILL || state_d == RINSE);
         heater_on_o      <= run_d && state_d == HEAT;
         drain_pump_o     <= run_d && (state_d == DRAIN || state_d == SPIN);
`ifdef PREWASH_EN
         motor_on_o       <= run_d && state_d inside {WASH, RINSE, SPIN, PREWASH};
`else
         motor_on_o       <= run_d && state_d inside {WASH, RINSE, SPIN};
`endif
         motor_fast_o     <= run_d && state_d == SPIN;
         done_o           <= state_d == DONE;
         fault_o          <= state_d == FAULT;
      end
   end
endmodule
